// File: rtl/nd_2to1.sv
// nd_2to1: two-input, one-output four-phase message merge node with round-robin arbitration.
// Define NS_ND_2TO1_RED_CHECK_EN to drop messages whose red field fails the src^dst^dat check.

`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 16
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 8
`endif

module nd_2to1 #(
  parameter int ASZ = `NS_ADDRESS_SIZE,
  parameter int DSZ = `NS_DATA_SIZE,
  parameter int RSZ = `NS_REDUN_SIZE
) (
  input  logic           i_clk,
  input  logic           reset,
  input  logic [ASZ-1:0] i0_src,
  input  logic [ASZ-1:0] i0_dst,
  input  logic [DSZ-1:0] i0_dat,
  input  logic [RSZ-1:0] i0_red,
  input  logic           i0_req,
  output logic           i0_ack,
  input  logic [ASZ-1:0] i1_src,
  input  logic [ASZ-1:0] i1_dst,
  input  logic [DSZ-1:0] i1_dat,
  input  logic [RSZ-1:0] i1_red,
  input  logic           i1_req,
  output logic           i1_ack,
  output logic [ASZ-1:0] o0_src,
  output logic [ASZ-1:0] o0_dst,
  output logic [DSZ-1:0] o0_dat,
  output logic [RSZ-1:0] o0_red,
  output logic           o0_req,
  input  logic           o0_ack,
  output logic           o_red_err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_ACK_WAIT
  } state_t;

  state_t state;
  state_t state_next;

  logic [ASZ-1:0] buf0_src;
  logic [ASZ-1:0] buf0_dst;
  logic [DSZ-1:0] buf0_dat;
  logic [RSZ-1:0] buf0_red;
  logic [ASZ-1:0] buf1_src;
  logic [ASZ-1:0] buf1_dst;
  logic [DSZ-1:0] buf1_dat;
  logic [RSZ-1:0] buf1_red;
  logic           full0;
  logic           full1;
  logic           last_sel;

  logic           accept0;
  logic           accept1;
  logic           good0;
  logic           good1;
  logic           load;
  logic           sel;

  assign accept0 = i0_req && !i0_ack && !full0;
  assign accept1 = i1_req && !i1_ack && !full1;

`ifdef NS_ND_2TO1_RED_CHECK_EN
  function automatic logic red_ok(input logic [ASZ-1:0] src,
                                  input logic [ASZ-1:0] dst,
                                  input logic [DSZ-1:0] dat,
                                  input logic [RSZ-1:0] red);
    return (RSZ'(src) ^ RSZ'(dst) ^ RSZ'(dat)) == red;
  endfunction

  logic red_err;

  assign good0 = red_ok(i0_src, i0_dst, i0_dat, i0_red);
  assign good1 = red_ok(i1_src, i1_dst, i1_dat, i1_red);

  // A failing message is still acked, but never marks its buffer full.
  always_ff @(posedge i_clk) begin
    if (!reset) begin
      red_err <= 1'b0;
    end else if ((accept0 && !good0) || (accept1 && !good1)) begin
      red_err <= 1'b1;
    end
  end

  assign o_red_err = red_err;
`else
  assign good0 = 1'b1;
  assign good1 = 1'b1;
  assign o_red_err = 1'b0;
`endif

  // Accept and consume of the same buffer are mutually exclusive via full_k.
  always_ff @(posedge i_clk) begin
    if (!reset) begin
      i0_ack <= 1'b0;
      full0  <= 1'b0;
    end else if (accept0) begin
      i0_ack <= 1'b1;
      full0  <= good0;
    end else begin
      if (i0_ack && !i0_req) i0_ack <= 1'b0;
      if (load && !sel) full0 <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!reset) begin
      i1_ack <= 1'b0;
      full1  <= 1'b0;
    end else if (accept1) begin
      i1_ack <= 1'b1;
      full1  <= good1;
    end else begin
      if (i1_ack && !i1_req) i1_ack <= 1'b0;
      if (load && sel) full1 <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept0) begin
      buf0_src <= i0_src;
      buf0_dst <= i0_dst;
      buf0_dat <= i0_dat;
      buf0_red <= i0_red;
    end
    if (accept1) begin
      buf1_src <= i1_src;
      buf1_dst <= i1_dst;
      buf1_dat <= i1_dat;
      buf1_red <= i1_red;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // On a tie the input that did not win last time is chosen.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    sel        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!o0_ack && (full0 || full1)) begin
          load       = 1'b1;
          sel        = (full0 && full1) ? !last_sel : full1;
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (o0_ack) state_next = ST_ACK_WAIT;
      end
      ST_ACK_WAIT: begin
        if (!o0_ack) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!reset) begin
      o0_req   <= 1'b0;
      o0_src   <= '0;
      o0_dst   <= '0;
      o0_dat   <= '0;
      o0_red   <= '0;
      last_sel <= 1'b1;
    end else if (load) begin
      o0_req   <= 1'b1;
      last_sel <= sel;
      if (sel) begin
        o0_src <= buf1_src;
        o0_dst <= buf1_dst;
        o0_dat <= buf1_dat;
        o0_red <= buf1_red;
      end else begin
        o0_src <= buf0_src;
        o0_dst <= buf0_dst;
        o0_dat <= buf0_dat;
        o0_red <= buf0_red;
      end
    end else if (state == ST_REQ && o0_ack) begin
      o0_req <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nd_2to1.sv
// Bench for nd_2to1: directed vector table, contention/backpressure/reset/redundancy sequences,
// and randomized traffic scored against per-input FIFOs of expected forwards.
module tb_nd_2to1;

  localparam int ASZ = 8;
  localparam int DSZ = 16;
  localparam int RSZ = 8;

  typedef struct {
    logic [ASZ-1:0] src;
    logic [ASZ-1:0] dst;
    logic [DSZ-1:0] dat;
    logic [RSZ-1:0] red;
  } msg_t;

  typedef struct {
    int   port;
    msg_t in;
    msg_t exp;
  } vec_t;

  logic           i_clk;
  logic           reset;
  logic [ASZ-1:0] i0_src, i0_dst, i1_src, i1_dst, o0_src, o0_dst;
  logic [DSZ-1:0] i0_dat, i1_dat, o0_dat;
  logic [RSZ-1:0] i0_red, i1_red, o0_red;
  logic           i0_req, i0_ack, i1_req, i1_ack, o0_req, o0_ack, o_red_err;

  int   n_cmp = 0;
  int   n_err = 0;
  bit   model_err = 1'b0;
  msg_t rx_q[$];
  msg_t q0[$];
  msg_t q1[$];
  vec_t vecs[4];

  nd_2to1 #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) dut (
    .i_clk(i_clk), .reset(reset),
    .i0_src(i0_src), .i0_dst(i0_dst), .i0_dat(i0_dat), .i0_red(i0_red),
    .i0_req(i0_req), .i0_ack(i0_ack),
    .i1_src(i1_src), .i1_dst(i1_dst), .i1_dat(i1_dat), .i1_red(i1_red),
    .i1_req(i1_req), .i1_ack(i1_ack),
    .o0_src(o0_src), .o0_dst(o0_dst), .o0_dat(o0_dat), .o0_red(o0_red),
    .o0_req(o0_req), .o0_ack(o0_ack),
    .o_red_err(o_red_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: time limit reached, got running, wanted finished");
    $fatal(1, "[TB] time limit reached");
  end

  // Reference rules: redundancy is the low RSZ bits of src xor dst xor dat.
  function automatic logic [RSZ-1:0] goodRed(input msg_t m);
    int x;
    x = int'(m.src) ^ int'(m.dst) ^ int'(m.dat);
    return RSZ'(x % (1 << RSZ));
  endfunction

  function automatic bit modelKeeps(input msg_t m);
`ifdef NS_ND_2TO1_RED_CHECK_EN
    return goodRed(m) == m.red;
`else
    return 1'b1;
`endif
  endfunction

  function automatic msg_t mk(input int s, input int d, input int t, input int r);
    msg_t m;
    m.src = ASZ'(s);
    m.dst = ASZ'(d);
    m.dat = DSZ'(t);
    m.red = RSZ'(r);
    return m;
  endfunction

  function automatic logic ackOf(input int p);
    return (p == 0) ? i0_ack : i1_ack;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, actual, expected);
    end
  endtask

  task automatic failTimeout(input string name);
    n_cmp++;
    n_err++;
    $display("[TB] FAIL %s: got timeout, wanted handshake", name);
  endtask

  task automatic drive(input int p, input msg_t m, input logic req);
    if (p == 0) begin
      i0_src = m.src; i0_dst = m.dst; i0_dat = m.dat; i0_red = m.red; i0_req = req;
    end else begin
      i1_src = m.src; i1_dst = m.dst; i1_dat = m.dat; i1_red = m.red; i1_req = req;
    end
  endtask

  // Full four-phase send on one input; called at a negedge.
  task automatic applyStimulus(input int p, input msg_t m);
    int t;
    drive(p, m, 1'b1);
    t = 0;
    do begin @(negedge i_clk); t++; end while (!ackOf(p) && t < 300);
    if (!ackOf(p)) begin
      failTimeout($sformatf("send%0d ack", p));
      drive(p, m, 1'b0);
      return;
    end
    drive(p, m, 1'b0);
    t = 0;
    do begin @(negedge i_clk); t++; end while (ackOf(p) && t < 300);
    if (ackOf(p)) failTimeout($sformatf("send%0d release", p));
  endtask

  task automatic sinkRun(input int n, input int max_dly);
    int   t;
    msg_t m;
    for (int k = 0; k < n; k++) begin
      t = 0;
      while (!o0_req && t < 400) begin @(negedge i_clk); t++; end
      if (!o0_req) begin failTimeout("sink req"); return; end
      m.src = o0_src; m.dst = o0_dst; m.dat = o0_dat; m.red = o0_red;
      rx_q.push_back(m);
      repeat ($urandom_range(max_dly, 0)) @(negedge i_clk);
      o0_ack = 1'b1;
      t = 0;
      do begin @(negedge i_clk); t++; end while (o0_req && t < 50);
      if (o0_req) failTimeout("sink drop");
      o0_ack = 1'b0;
      @(negedge i_clk);
    end
  endtask

  task automatic doReset();
    msg_t z;
    z = mk(0, 0, 0, 0);
    reset = 1'b0;
    drive(0, z, 1'b0);
    drive(1, z, 1'b0);
    o0_ack = 1'b0;
    repeat (2) @(negedge i_clk);
    reset = 1'b1;
    model_err = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic countIdle(input string name, input int cycles);
    int extra;
    extra = 0;
    repeat (cycles) begin @(negedge i_clk); if (o0_req) extra++; end
    checkOutput(name, extra, 0);
  endtask

  // Each output must match the head of one input's expected FIFO.
  task automatic runTraffic(input string tag, input int n, input int max_dly, input bit rnd);
    msg_t m0[$];
    msg_t m1[$];
    msg_t m;
    msg_t r;
    int   exp_n;
    bit   ok;
    exp_n = 0;
    q0.delete(); q1.delete(); rx_q.delete();
    for (int i = 0; i < n; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (rnd) begin
          m.src = ASZ'($urandom);
          m.dst = ASZ'($urandom);
          m.dat = DSZ'($urandom);
          m.red = goodRed(m) ^ RSZ'(($urandom_range(3, 0) == 0) ? 1 : 0);
        end else begin
          m = mk(p, 1 - p, i, 0);
          m.red = goodRed(m);
        end
        if (p == 0) m0.push_back(m); else m1.push_back(m);
        if (modelKeeps(m)) begin
          exp_n++;
          if (p == 0) q0.push_back(m); else q1.push_back(m);
        end else begin
          model_err = 1'b1;
        end
      end
    end
    fork
      begin for (int i = 0; i < m0.size(); i++) applyStimulus(0, m0[i]); end
      begin for (int i = 0; i < m1.size(); i++) applyStimulus(1, m1[i]); end
      sinkRun(exp_n, max_dly);
    join
    countIdle({tag, " no extra"}, 12);
    for (int k = 0; k < rx_q.size(); k++) begin
      r = rx_q[k];
      ok = 1'b0;
      if (q0.size() > 0 && r == q0[0]) begin q0.pop_front(); ok = 1'b1; end
      else if (q1.size() > 0 && r == q1[0]) begin q1.pop_front(); ok = 1'b1; end
      n_cmp++;
      if (!ok) begin
        n_err++;
        $display("[TB] FAIL %s msg%0d: got src=%0h dat=%0h, wanted a FIFO head (q0 %0d left, q1 %0d left)",
                 tag, k, r.src, r.dat, q0.size(), q1.size());
      end
    end
    checkOutput({tag, " count"}, rx_q.size(), exp_n);
    checkOutput({tag, " leftover"}, q0.size() + q1.size(), 0);
    checkOutput({tag, " red_err"}, o_red_err, model_err);
  endtask

  initial begin
    int   p;
    int   bad;
    int   held_bad;
    int   exp_n;
    msg_t a, b, c, x, y, e, m1, m2;

    vecs[0].port = 0; vecs[0].in = mk(8'h00, 8'h01, 16'h0005, 8'h04); vecs[0].exp = mk(8'h00, 8'h01, 16'h0005, 8'h04);
    vecs[1].port = 1; vecs[1].in = mk(8'h03, 8'h07, 16'h0010, 8'h14); vecs[1].exp = mk(8'h03, 8'h07, 16'h0010, 8'h14);
    vecs[2].port = 0; vecs[2].in = mk(8'hff, 8'h0f, 16'h1234, 8'hc4); vecs[2].exp = mk(8'hff, 8'h0f, 16'h1234, 8'hc4);
    vecs[3].port = 1; vecs[3].in = mk(8'haa, 8'h55, 16'hffff, 8'h00); vecs[3].exp = mk(8'haa, 8'h55, 16'hffff, 8'h00);

    $display("[TB] reset values");
    reset = 1'b0;
    o0_ack = 1'b0;
    drive(0, mk(0, 0, 0, 0), 1'b0);
    drive(1, mk(0, 0, 0, 0), 1'b0);
    repeat (3) @(negedge i_clk);
    checkOutput("rst i0_ack", i0_ack, 0);
    checkOutput("rst i1_ack", i1_ack, 0);
    checkOutput("rst o0_req", o0_req, 0);
    checkOutput("rst o_red_err", o_red_err, 0);
    checkOutput("rst o0_dat", o0_dat, 0);
    checkOutput("rst o0_src", o0_src, 0);
    reset = 1'b1;
    @(negedge i_clk);

    $display("[TB] single-message vectors");
    for (int v = 0; v < 4; v++) begin
      p = vecs[v].port;
      drive(p, vecs[v].in, 1'b1);
      @(negedge i_clk);
      checkOutput($sformatf("vec%0d ack+1", v), ackOf(p), 1);
      checkOutput($sformatf("vec%0d req+1", v), o0_req, 0);
      drive(p, vecs[v].in, 1'b0);
      @(negedge i_clk);
      checkOutput($sformatf("vec%0d req+2", v), o0_req, 1);
      checkOutput($sformatf("vec%0d src", v), o0_src, vecs[v].exp.src);
      checkOutput($sformatf("vec%0d dst", v), o0_dst, vecs[v].exp.dst);
      checkOutput($sformatf("vec%0d dat", v), o0_dat, vecs[v].exp.dat);
      checkOutput($sformatf("vec%0d red", v), o0_red, vecs[v].exp.red);
      checkOutput($sformatf("vec%0d ack release", v), ackOf(p), 0);
      checkOutput($sformatf("vec%0d other ack", v), ackOf(1 - p), 0);
      o0_ack = 1'b1;
      @(negedge i_clk);
      checkOutput($sformatf("vec%0d req drop", v), o0_req, 0);
      o0_ack = 1'b0;
      repeat (2) @(negedge i_clk);
    end

    $display("[TB] contention");
    doReset();
    for (int rep = 0; rep < 2; rep++) begin
      rx_q.delete();
      fork
        applyStimulus(0, mk(0, 1, 3, 2));
        applyStimulus(1, mk(1, 0, 9, 8));
        sinkRun(2, 0);
      join
      checkOutput($sformatf("rr%0d count", rep), rx_q.size(), 2);
      if (rx_q.size() == 2) begin
        checkOutput($sformatf("rr%0d first", rep), rx_q[0].dat, 3);
        checkOutput($sformatf("rr%0d second", rep), rx_q[1].dat, 9);
      end
    end

    $display("[TB] streaming counters");
    doReset();
    runTraffic("stream", 16, 4, 1'b0);

    $display("[TB] backpressure");
    doReset();
    a = mk(0, 1, 16'h00a1, 0); a.red = goodRed(a);
    b = mk(0, 1, 16'h00b2, 0); b.red = goodRed(b);
    c = mk(0, 1, 16'h00c3, 0); c.red = goodRed(c);
    rx_q.delete();
    applyStimulus(0, a);
    applyStimulus(0, b);
    checkOutput("bp o0_req", o0_req, 1);
    checkOutput("bp o0 holds first", o0_dat, a.dat);
    fork
      applyStimulus(0, c);
      begin
        bad = 0;
        held_bad = 0;
        repeat (20) begin
          @(negedge i_clk);
          if (i0_ack) bad++;
          if (!o0_req || o0_dat != a.dat) held_bad++;
        end
        checkOutput("bp third not acked", bad, 0);
        checkOutput("bp o0 stable", held_bad, 0);
        sinkRun(3, 1);
      end
    join
    checkOutput("bp count", rx_q.size(), 3);
    if (rx_q.size() == 3) begin
      checkOutput("bp order0", rx_q[0].dat, a.dat);
      checkOutput("bp order1", rx_q[1].dat, b.dat);
      checkOutput("bp order2", rx_q[2].dat, c.dat);
    end

    $display("[TB] reset mid-operation");
    doReset();
    e = mk(8'h10, 8'h20, 16'h0030, 8'h55);
    x = mk(0, 1, 16'h0011, 0); x.red = goodRed(x);
    y = mk(1, 0, 16'h0022, 0); y.red = goodRed(y);
    if (!modelKeeps(e)) model_err = 1'b1;
    applyStimulus(0, e);
    applyStimulus(0, x);
    drive(1, y, 1'b1);
    @(negedge i_clk);
    checkOutput("mid setup o0_req", o0_req, 1);
    checkOutput("mid setup i1_ack", i1_ack, 1);
    checkOutput("mid setup red_err", o_red_err, model_err);
    reset = 1'b0;
    drive(1, y, 1'b0);
    @(negedge i_clk);
    checkOutput("mid o0_req", o0_req, 0);
    checkOutput("mid i0_ack", i0_ack, 0);
    checkOutput("mid i1_ack", i1_ack, 0);
    checkOutput("mid o_red_err", o_red_err, 0);
    reset = 1'b1;
    model_err = 1'b0;
    countIdle("mid no stale", 15);

    $display("[TB] redundancy check");
    doReset();
    rx_q.delete();
    m1 = mk(1, 2, 4, 7);
    m2 = mk(1, 2, 4, 6);
    exp_n = int'(modelKeeps(m1)) + int'(modelKeeps(m2));
    if (!modelKeeps(m2)) model_err = 1'b1;
    applyStimulus(0, m1);
    applyStimulus(0, m2);
    sinkRun(exp_n, 0);
    countIdle("red no extra", 10);
    checkOutput("red count", rx_q.size(), exp_n);
    if (rx_q.size() > 0) checkOutput("red first dat", rx_q[0].dat, 4);
    checkOutput("red err flag", o_red_err, model_err);
    repeat (5) @(negedge i_clk);
    checkOutput("red err sticky", o_red_err, model_err);

    $display("[TB] random traffic");
    doReset();
    runTraffic("random", 12, 3, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
